// File: rtl/compress_handler.sv
`default_nettype none
// ============================================================================
// Module  : compress_handler
// Brief   : Reads bytes from RAM (MSB first) and emits {value, run} RLE codes.
// Rev     : 1.0 - initial release
// ============================================================================
module compress_handler #(
    parameter int ADDR_W = 16,
    parameter int RUN_W  = 7
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddress,
    input  logic [ADDR_W-1:0] numBytes,
    output logic [ADDR_W-1:0] ramAddress,
    output logic              ramReadSignal,
    input  logic [7:0]        ramDataIn,
    output logic [RUN_W:0]    codeOut,
    output logic              codeValid,
    input  logic              codeReady,
    output logic              busy,
    output logic              done
);

    localparam logic [RUN_W-1:0]  c_MAX_RUN = '1;
    localparam logic [ADDR_W-1:0] c_ONE     = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ_REQ  = 3'd1,
        S_READ_WAIT = 3'd2,
        S_SCAN      = 3'd3,
        S_EMIT      = 3'd4,
        S_FINISH    = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    state_t            r_state, w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [7:0]        r_shift;
    logic [2:0]        r_bitptr;
    logic              r_value;
    logic [RUN_W-1:0]  r_run;
    logic [RUN_W:0]    r_code;
    logic              r_flush;

    logic   w_bit;
    logic   w_break;
    state_t w_adv_state;

    assign w_bit   = r_shift[r_bitptr];
    // Current run cannot absorb this bit: value change or run saturated
    assign w_break = (r_run != '0) && ((w_bit != r_value) || (r_run == c_MAX_RUN));

    always_comb begin
        w_adv_state = S_SCAN;
        if (r_bitptr == 3'd0) begin
            w_adv_state = (r_remaining == c_ONE) ? S_FINISH : S_READ_REQ;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        ramReadSignal = 1'b0;
        codeValid     = 1'b0;
        done          = 1'b0;
        busy          = 1'b1;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (numBytes == '0) ? S_FINISH : S_READ_REQ;
                end
            end
            S_READ_REQ: begin
                ramReadSignal = 1'b1;
                w_next        = S_READ_WAIT;
            end
            S_READ_WAIT: w_next = S_SCAN;
            S_SCAN:      w_next = w_break ? S_EMIT : w_adv_state;
            S_EMIT: begin
                codeValid = 1'b1;
                if (codeReady) begin
                    w_next = r_flush ? S_DONE : w_adv_state;
                end
            end
            S_FINISH:    w_next = (r_run != '0) ? S_EMIT : S_DONE;
            S_DONE: begin
                done   = 1'b1;
                busy   = 1'b0;
                w_next = S_IDLE;
            end
            default:     w_next = S_IDLE;
        endcase
    end

    assign ramAddress = (r_state == S_READ_REQ) ? r_addr : '0;
    assign codeOut    = r_code;

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_shift     <= '0;
            r_bitptr    <= '0;
            r_value     <= 1'b0;
            r_run       <= '0;
            r_code      <= '0;
            r_flush     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr      <= baseAddress;
                        r_remaining <= numBytes;
                        r_run       <= '0;
                        r_flush     <= 1'b0;
                    end
                end
                S_READ_WAIT: begin
                    r_shift  <= ramDataIn;
                    r_bitptr <= 3'd7;
                end
                S_SCAN, S_EMIT: begin
                    if (r_state == S_SCAN && w_break) begin
                        r_code <= {r_value, r_run};
                    end else if (r_state == S_EMIT && codeReady && r_flush) begin
                        r_run   <= '0;
                        r_flush <= 1'b0;
                    end else if (r_state == S_SCAN || codeReady) begin
                        // Consume the current bit: start a new run or extend the open one
                        if (r_state == S_EMIT || r_run == '0) begin
                            r_value <= w_bit;
                            r_run   <= RUN_W'(1);
                        end else begin
                            r_run   <= r_run + RUN_W'(1);
                        end
                        if (r_bitptr == 3'd0) begin
                            r_addr      <= r_addr + c_ONE;
                            r_remaining <= r_remaining - c_ONE;
                        end else begin
                            r_bitptr <= r_bitptr - 3'd1;
                        end
                    end
                end
                S_FINISH: begin
                    if (r_run != '0) begin
                        r_code  <= {r_value, r_run};
                        r_flush <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
